// File: rtl/sar_pkg.sv
// Shared constants for the successive-approximation search controller.
package sar_pkg;
   localparam int SAR_WIDTH = 4;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_TRY    = 2'd1;
   localparam logic [1:0] S_VERIFY = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;
endpackage

// File: rtl/sar_search_ctrl.sv
// SAR controller: drives a trial operand to an external comparator and
// resolves one bit per cycle, MSB first, reporting result and step count.
module sar_search_ctrl
   import sar_pkg::*;
#(
   parameter int WIDTH = SAR_WIDTH,
   parameter int CNTW  = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             cmp_eql,
   input  logic             cmp_gt,
   input  logic             cmp_lt,
   output logic [WIDTH-1:0] guess,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [CNTW-1:0]  steps,
   output logic             err
);
   localparam int KW = $clog2(WIDTH);

   logic [1:0]       r_state;
   logic [KW-1:0]    r_k;
   logic [WIDTH-1:0] r_guess;
   logic [WIDTH-1:0] r_result;
   logic [CNTW-1:0]  r_steps;
   logic             r_err;

   logic             w_valid;
   logic             w_k0;
   logic [WIDTH-1:0] w_bit;
   logic [WIDTH-1:0] w_low;

   // exactly one flag high: odd parity but not all three
   assign w_valid = (cmp_eql ^ cmp_gt ^ cmp_lt)
                  & ~(cmp_eql & cmp_gt & cmp_lt);
   assign w_k0    = (r_k == '0);
   assign w_bit   = WIDTH'(1) << r_k;
   assign w_low   = w_bit >> 1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_k      <= '0;
         r_guess  <= '0;
         r_result <= '0;
         r_steps  <= '0;
         r_err    <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_guess <= WIDTH'(1) << (WIDTH - 1);
                  r_k     <= KW'(WIDTH - 1);
                  r_steps <= '0;
                  r_err   <= 1'b0;
                  r_state <= S_TRY;
               end
            end
            S_TRY: begin
               r_steps <= r_steps + CNTW'(1);
               if (!w_valid || (cmp_lt && w_k0)) begin
                  r_err    <= 1'b1;
                  r_result <= r_guess;
                  r_state  <= S_DONE;
               end else if (cmp_eql) begin
                  r_result <= r_guess;
                  r_state  <= S_DONE;
               end else if (cmp_gt) begin
                  // at k=0 w_low is zero, so this only clears bit 0
                  r_guess <= (r_guess & ~w_bit) | w_low;
                  if (w_k0) r_state <= S_VERIFY;
                  else      r_k     <= r_k - KW'(1);
               end else begin
                  r_guess <= r_guess | w_low;
                  r_k     <= r_k - KW'(1);
               end
            end
            S_VERIFY: begin
               r_steps  <= r_steps + CNTW'(1);
               r_result <= r_guess;
               r_err    <= ~(w_valid & cmp_eql);
               r_state  <= S_DONE;
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign guess  = r_guess;
   assign result = r_result;
   assign steps  = r_steps;
   assign err    = r_err;
   assign busy   = (r_state == S_TRY) || (r_state == S_VERIFY);
   assign done   = (r_state == S_DONE);

endmodule
